// File: rtl/rotor_stack.sv
// rotor_stack: Enigma rotor-position unit with notch-driven stepping, optional double-step and reverse mode
// Ports: clk, reset (async, active-high); load/load_pos set positions (out-of-range fields become 0,
// flagged on load_err); step/step_dir request one forward/reverse step; pos holds all positions,
// ready marks positions loaded, stepped/step_mask describe the step just applied.
module rotor_stack #(
  parameter int NUM_ROTORS = 3,
  parameter int MODULUS = 26,
  parameter int POS_W = 5,
  parameter logic [NUM_ROTORS*POS_W-1:0] NOTCH_POS = {5'd16, 5'd4, 5'd21},
  parameter bit DOUBLE_STEP = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic [NUM_ROTORS*POS_W-1:0] load_pos,
  input  logic                        step,
  input  logic                        step_dir,
  output logic [NUM_ROTORS*POS_W-1:0] pos,
  output logic                        ready,
  output logic                        stepped,
  output logic [NUM_ROTORS-1:0]       step_mask,
  output logic                        load_err
);
  localparam logic [POS_W-1:0] LAST = POS_W'(MODULUS - 1);
  typedef enum logic {UNLOADED, READY} state_t;
  state_t state, state_nxt;
  logic [NUM_ROTORS-1:0] mv;
  logic [NUM_ROTORS*POS_W-1:0] ld_pos, st_pos;
  logic ld_err, do_step;

  function automatic logic [POS_W-1:0] up(input logic [POS_W-1:0] v);
    return v == LAST ? '0 : v + 1'b1;
  endfunction

  function automatic logic [POS_W-1:0] dn(input logic [POS_W-1:0] v);
    return v == '0 ? LAST : v - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= UNLOADED;
    else state <= state_nxt;

  always_comb state_nxt = load ? READY : state;

  assign ready = state == READY;
  assign do_step = ready && step && !load;

  // Reverse carry triggers one position past the notch so it exactly undoes odometer carry.
  always_comb begin
    mv = '0;
    st_pos = pos;
    ld_pos = '0;
    ld_err = 1'b0;
    mv[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++)
      mv[i] = step_dir ? mv[i-1] && pos[POS_W*(i-1) +: POS_W] == up(NOTCH_POS[POS_W*(i-1) +: POS_W])
            : DOUBLE_STEP ? pos[POS_W*(i-1) +: POS_W] == NOTCH_POS[POS_W*(i-1) +: POS_W] ||
                            (i <= NUM_ROTORS - 2 && pos[POS_W*i +: POS_W] == NOTCH_POS[POS_W*i +: POS_W])
            : mv[i-1] && pos[POS_W*(i-1) +: POS_W] == NOTCH_POS[POS_W*(i-1) +: POS_W];
    for (int i = 0; i < NUM_ROTORS; i++) begin
      st_pos[POS_W*i +: POS_W] = !mv[i] ? pos[POS_W*i +: POS_W]
                               : step_dir ? dn(pos[POS_W*i +: POS_W]) : up(pos[POS_W*i +: POS_W]);
      ld_pos[POS_W*i +: POS_W] = int'(load_pos[POS_W*i +: POS_W]) < MODULUS ? load_pos[POS_W*i +: POS_W] : '0;
      ld_err = ld_err || int'(load_pos[POS_W*i +: POS_W]) >= MODULUS;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pos <= '0;
      stepped <= 1'b0;
      step_mask <= '0;
      load_err <= 1'b0;
    end else begin
      stepped <= do_step;
      step_mask <= do_step ? mv : '0;
      pos <= load ? ld_pos : do_step ? st_pos : pos;
      load_err <= load ? ld_err : load_err;
    end
endmodule

// File: tb/tb_rotor_stack.sv
// tb_rotor_stack: scoreboard bench running double-step and odometer instances against a reference model
module tb_rotor_stack;
  typedef struct packed {logic [14:0] pos; logic [2:0] mask;} exp_t;
  logic clk = 1'b0, reset = 1'b1, load = 1'b0, step = 1'b0, step_dir = 1'b0;
  logic [14:0] load_pos = '0;
  logic [14:0] ds_pos, od_pos;
  logic [2:0] ds_mask, od_mask;
  logic ds_ready, od_ready, ds_st, od_st, ds_err, od_err;
  int checks = 0, errors = 0;
  int notch[3] = '{21, 4, 16};
  int mp[2][3];
  bit mloaded = 1'b0, merr = 1'b0;
  exp_t q0[$], q1[$];
  logic [14:0] tp[4];
  logic [2:0] tm[4];

  rotor_stack #(.DOUBLE_STEP(1'b1)) u_ds (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .step(step), .step_dir(step_dir),
    .pos(ds_pos), .ready(ds_ready), .stepped(ds_st), .step_mask(ds_mask), .load_err(ds_err));

  rotor_stack #(.DOUBLE_STEP(1'b0)) u_od (
    .clk(clk), .reset(reset), .load(load), .load_pos(load_pos), .step(step), .step_dir(step_dir),
    .pos(od_pos), .ready(od_ready), .stepped(od_st), .step_mask(od_mask), .load_err(od_err));

  always #5 clk = ~clk;

  function automatic logic [14:0] pk(int a2, int a1, int a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", n, a, e);
    end
  endtask

  // Rotor i carries when every faster rotor sits on its trigger position (odometer / reverse);
  // the double-step rule looks only at the neighbour plus the middle rotor's own notch.
  task automatic model_step(int k, bit dir);
    bit mv[3];
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      mv[i] = 1'b1;
      for (int j = 0; j < i; j++)
        if (dir) mv[i] &= mp[k][j] == (notch[j] + 1) % 26;
        else if (k == 1) mv[i] &= mp[k][j] == notch[j];
      if (!dir && k == 0 && i > 0) mv[i] = mp[0][i-1] == notch[i-1] || (i == 1 && mp[0][1] == notch[1]);
    end
    for (int i = 0; i < 3; i++) begin
      if (mv[i]) mp[k][i] = dir ? (mp[k][i] + 25) % 26 : (mp[k][i] + 1) % 26;
      e.mask[i] = mv[i];
    end
    e.pos = pk(mp[k][2], mp[k][1], mp[k][0]);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic chk_state();
    chk("ds_pos", ds_pos, pk(mp[0][2], mp[0][1], mp[0][0]));
    chk("od_pos", od_pos, pk(mp[1][2], mp[1][1], mp[1][0]));
    chk("ds_ready", ds_ready, mloaded);
    chk("od_ready", od_ready, mloaded);
    chk("ds_load_err", ds_err, merr);
    chk("od_load_err", od_err, merr);
  endtask

  task automatic cycle(bit ld, logic [14:0] lp, bit st, bit dir);
    load = ld;
    load_pos = lp;
    step = st;
    step_dir = dir;
    if (ld) begin
      merr = 1'b0;
      mloaded = 1'b1;
      for (int i = 0; i < 3; i++) begin
        int f;
        f = int'(lp[5*i +: 5]);
        if (f >= 26) merr = 1'b1;
        for (int k = 0; k < 2; k++) mp[k][i] = f < 26 ? f : 0;
      end
    end else if (st && mloaded) begin
      model_step(0, dir);
      model_step(1, dir);
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  always @(negedge clk) begin
    if (ds_st) begin
      if (q0.size() == 0) chk("ds_unexpected_step", 1, 0);
      else begin
        exp_t e;
        e = q0.pop_front();
        chk("ds_step_pos", ds_pos, e.pos);
        chk("ds_step_mask", ds_mask, e.mask);
      end
    end
    if (od_st) begin
      if (q1.size() == 0) chk("od_unexpected_step", 1, 0);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("od_step_pos", od_pos, e.pos);
        chk("od_step_mask", od_mask, e.mask);
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) mp[k][i] = 0;
    tp = '{{5'd0, 5'd3, 5'd21}, {5'd0, 5'd4, 5'd22}, {5'd1, 5'd5, 5'd23}, {5'd1, 5'd5, 5'd24}};
    tm = '{3'b001, 3'b011, 3'b111, 3'b001};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pos", ds_pos, 0);
    chk("reset_stepped", ds_st, 0);
    chk("reset_mask", ds_mask, 0);
    reset = 1'b0;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("unloaded_stepped", ds_st, 0);
    cycle(1'b1, pk(0, 3, 20), 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("dstep_seq_pos", ds_pos, tp[n]);
      chk("dstep_seq_mask", ds_mask, tm[n]);
    end
    cycle(1'b1, pk(0, 25, 25), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, pk(0, 4, 21), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("odo_carry_pos", od_pos, pk(1, 5, 22));
    cycle(1'b1, pk(25, 4, 21), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("odo_wrap_pos", od_pos, pk(0, 5, 22));
    cycle(1'b1, pk(0, 4, 22), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("rev_pos", od_pos, pk(0, 3, 21));
    cycle(1'b1, pk(0, 0, 0), 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("rev_wrap_pos", od_pos, pk(0, 0, 25));
    cycle(1'b1, pk(3, 30, 7), 1'b0, 1'b0);
    chk("bad_load_err", ds_err, 1);
    cycle(1'b1, pk(3, 2, 7), 1'b1, 1'b0);
    chk("load_wins_stepped", ds_st, 0);
    chk("load_wins_pos", ds_pos, pk(3, 2, 7));
    for (int n = 0; n < 6; n++) cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_pos", ds_pos, 0);
    chk("async_reset_ready", ds_ready, 0);
    mloaded = 1'b0;
    merr = 1'b0;
    for (int k = 0; k < 2; k++) for (int i = 0; i < 3; i++) mp[k][i] = 0;
    #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) cycle(1'b0, '0, 1'b1, 1'b0);
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 9) == 0) cycle(1'b1, 15'($urandom), 1'($urandom), 1'b0);
      else cycle(1'b0, '0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0);
    end
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    chk("ds_queue_drained", q0.size(), 0);
    chk("od_queue_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
